// File: rtl/connect_four_pkg.sv
`default_nettype none
// ============================================================================
// Module      : connect_four_pkg
// Description : Shared types and helpers for the connect-four move sequencer.
//               light_t      - per-cell light code driven to the light array
//               drop_state_t - state of the drop sequencer
//               cell_index   - flattens (row, col) into a linear cell number
// Revision    : 1.0 - initial release
// ============================================================================
package connect_four_pkg;

    typedef enum logic [1:0] {
        LIGHT_OFF = 2'b00,
        RED_ON    = 2'b01,
        GREEN_ON  = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FALL   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FULL   = 2'd3
    } drop_state_t;

    // Row 0 is the top row; cells are laid out row-major.
    function automatic int unsigned cell_index(input int unsigned row,
                                               input int unsigned col,
                                               input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/drop_timer.sv
`default_nettype none
// ============================================================================
// Module      : drop_timer
// Description : Per-row dwell counter for the falling token. Counts
//               0..DROP_TICKS-1 while enabled and pulses row_done on the last
//               tick, then wraps so the next row starts from zero.
// Ports       : clock    - system clock, rising edge
//               reset    - asynchronous active-low reset
//               start    - restart the count at tick 0 (new drop accepted)
//               enable   - count while high (token is falling)
//               row_done - high during the final tick of the current row
// Revision    : 1.0 - initial release
// ============================================================================
module drop_timer
    import connect_four_pkg::*;
#(
    parameter int DROP_TICKS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic enable,
    output logic row_done
);

    localparam int c_TICK_W = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
    localparam logic [c_TICK_W-1:0] c_LAST_TICK = c_TICK_W'(DROP_TICKS - 1);

    logic [c_TICK_W-1:0] r_tick;

    assign row_done = enable && (r_tick == c_LAST_TICK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tick <= '0;
        end else if (start || row_done) begin
            r_tick <= '0;
        end else if (enable) begin
            r_tick <= r_tick + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/drop_turn_controller.sv
`default_nettype none
// ============================================================================
// Module      : drop_turn_controller
// Description : Sequences each connect-four move. Accepts a column pick,
//               animates the token falling row by row, commits it to the
//               lowest free cell and hands the turn to the other player.
// Ports       : clock       - system clock, rising edge
//               reset       - asynchronous active-low reset
//               drop_req    - 1-cycle request to drop into col_sel
//               col_sel     - requested column, sampled with drop_req
//               board       - cell codes, cell (r,c) at [2*(r*COLS+c)+:2]
//               player      - player to move (10 green, 01 red)
//               busy        - high while a drop is falling or committing
//               drop_ack    - 1-cycle pulse when the token is committed
//               drop_reject - 1-cycle pulse when a request is refused
//               board_full  - high once every cell is occupied
// Revision    : 1.0 - initial release
// ============================================================================
module drop_turn_controller
    import connect_four_pkg::*;
#(
    parameter int ROWS       = 6,
    parameter int COLS       = 7,
    parameter int DROP_TICKS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     drop_req,
    input  logic [$clog2(COLS)-1:0]  col_sel,
    output logic [ROWS*COLS*2-1:0]   board,
    output logic [1:0]               player,
    output logic                     busy,
    output logic                     drop_ack,
    output logic                     drop_reject,
    output logic                     board_full
);

    localparam int c_CELLS = ROWS * COLS;
    localparam int c_ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_COL_W = $clog2(COLS);
    localparam int c_IDX_W = $clog2(c_CELLS);
    localparam int c_CNT_W = $clog2(c_CELLS + 1);

    localparam logic [c_ROW_W-1:0] c_LAST_ROW  = c_ROW_W'(ROWS - 1);
    localparam logic [c_CNT_W-1:0] c_CELLS_M1  = c_CNT_W'(c_CELLS - 1);

    drop_state_t          r_state;
    drop_state_t          w_state_nxt;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_COL_W-1:0]   r_col;
    light_t               r_player;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_reject;
    logic                 w_reject_nxt;
    logic                 w_start;
    logic                 w_fall;
    logic                 w_commit;
    logic                 w_row_done;
    logic                 w_at_bottom;
    logic                 w_landed;
    logic                 w_col_ok;
    logic                 w_col_open;
    logic                 w_last_cell;
    logic [c_IDX_W-1:0]   w_top_idx;
    logic [c_IDX_W-1:0]   w_cur_idx;
    logic [c_IDX_W-1:0]   w_below_idx;
    light_t               w_cells [c_CELLS];

    assign w_fall   = (r_state == ST_FALL);
    assign w_commit = (r_state == ST_COMMIT);

    // ------------------------------------------------------------------
    // Occupancy lookups
    // ------------------------------------------------------------------
    assign w_col_ok   = (32'(col_sel) < COLS);
    assign w_top_idx  = w_col_ok ? c_IDX_W'(cell_index(0, 32'(col_sel), COLS)) : '0;
    // A column is playable as long as its top cell is still empty.
    assign w_col_open = w_col_ok && (w_cells[w_top_idx] == LIGHT_OFF);

    assign w_cur_idx   = c_IDX_W'(cell_index(32'(r_row), 32'(r_col), COLS));
    assign w_at_bottom = (r_row == c_LAST_ROW);
    // On the bottom row there is no cell below; point at the current cell so
    // the lookup never leaves the array.
    assign w_below_idx = w_at_bottom ? w_cur_idx
                                     : c_IDX_W'(cell_index(32'(r_row) + 1, 32'(r_col), COLS));
    assign w_landed    = w_at_bottom || (w_cells[w_below_idx] != LIGHT_OFF);
    assign w_last_cell = (r_count == c_CELLS_M1);

    // ------------------------------------------------------------------
    // Row dwell timer
    // ------------------------------------------------------------------
    drop_timer #(
        .DROP_TICKS (DROP_TICKS)
    ) u_drop_timer (
        .clock    (clock),
        .reset    (reset),
        .start    (w_start),
        .enable   (w_fall),
        .row_done (w_row_done)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_reject_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (drop_req) begin
                    if (w_col_open) begin
                        w_state_nxt = ST_FALL;
                        w_start     = 1'b1;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            ST_FALL: begin
                if (w_row_done && w_landed) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // r_count still excludes the token being written this cycle.
                w_state_nxt = w_last_cell ? ST_FULL : ST_IDLE;
            end
            ST_FULL: begin
                if (drop_req) begin
                    w_reject_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_player <= GREEN_ON;
            r_count  <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_reject <= w_reject_nxt;
            if (w_start) begin
                r_row <= '0;
                r_col <= col_sel;
            end else if (w_fall && w_row_done && !w_landed) begin
                r_row <= r_row + 1'b1;
            end
            if (w_commit) begin
                r_player <= (r_player == GREEN_ON) ? RED_ON : GREEN_ON;
                r_count  <= r_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cell storage and board overlay
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < c_CELLS; i++) begin : g_cell
            light_t r_cell;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_cell <= LIGHT_OFF;
                end else if (w_commit && (w_cur_idx == c_IDX_W'(i))) begin
                    r_cell <= r_player;
                end
            end

            assign w_cells[i] = r_cell;
            // The moving token is shown on top of the (empty) cell it occupies.
            assign board[2*i +: 2] = (busy && (w_cur_idx == c_IDX_W'(i))) ? r_player : r_cell;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign player      = r_player;
    assign busy        = w_fall || w_commit;
    assign drop_ack    = w_commit;
    assign drop_reject = r_reject;
    assign board_full  = (r_state == ST_FULL);

endmodule
`default_nettype wire
